// File: rtl/branch_resolver.sv
// branch_resolver
//
// Execute-stage branch/jump resolver. It takes the ALU flags from SUB rs1-rs2
// together with the decoded funct3, PC, immediate and rs1. From these it
// computes the actual outcome and next PC of each control instruction and
// checks that result against the static prediction made in fetch. When the
// prediction is wrong it raises a PC redirect to fetch and holds it until
// fetch takes it. It also keeps wrapping counters of branches and mispredicts.
//
// Ports
//   clk_i, rst_ni                 clock (rising edge), async active-low reset
//   flush_i                       trap/pipeline flush, kills pending work
//   in_valid_i / in_ready_o       execute-stage handshake (ready from state only)
//   in_is_branch_i/_jal_i/_jalr_i one-hot instruction class (all 0: non-control)
//   in_funct3_i                   branch condition
//   in_pc_i, in_imm_i, in_rs1_i   PC, sign-extended immediate, rs1 value
//   in_pred_taken_i               fetch's static prediction
//   zero_i/sign_i/overflow_i/carry_i  flags from SUB rs1-rs2 (carry = borrow)
//   res_*_o                       registered result, res_valid_o pulses once
//   redir_valid_o/redir_ready_i   redirect handshake, redir_pc_o held stable
//   branch_cnt_o, mispred_cnt_o   wrapping performance counters
module branch_resolver #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             in_is_branch_i,
  input  logic             in_is_jal_i,
  input  logic             in_is_jalr_i,
  input  logic [2:0]       in_funct3_i,
  input  logic [31:0]      in_pc_i,
  input  logic [31:0]      in_imm_i,
  input  logic [31:0]      in_rs1_i,
  input  logic             in_pred_taken_i,
  input  logic             zero_i,
  input  logic             sign_i,
  input  logic             overflow_i,
  input  logic             carry_i,
  output logic             res_valid_o,
  output logic             res_taken_o,
  output logic [31:0]      res_target_o,
  output logic             res_illegal_o,
  output logic             res_misalign_o,
  output logic             redir_valid_o,
  input  logic             redir_ready_i,
  output logic [31:0]      redir_pc_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  typedef enum logic [0:0] {StIdle, StRedir} state_e;

  state_e state_q, state_d;

  logic             res_valid_q;
  logic             res_taken_q;
  logic [31:0]      res_target_q;
  logic             res_illegal_q;
  logic             res_misalign_q;
  logic [31:0]      redir_pc_q;
  logic [CNT_W-1:0] branch_cnt_q;
  logic [CNT_W-1:0] mispred_cnt_q;

  logic        is_ctrl;
  logic        accept;
  logic        cond;
  logic        f3_illegal;
  logic        br_illegal;
  logic        taken;
  logic [31:0] pc_plus_imm;
  logic [31:0] pc_plus_4;
  logic [31:0] jalr_sum;
  logic [31:0] jalr_target;
  logic [31:0] target;
  logic        misalign;
  logic        redirect;

  // ---------------------------------------------------------------------------
  // Accept: exactly one class bit set; malformed class combinations are
  // treated like non-control instructions and ignored.
  // ---------------------------------------------------------------------------
  always_comb begin
    is_ctrl = 1'b0;
    unique case ({in_is_branch_i, in_is_jal_i, in_is_jalr_i})
      3'b100, 3'b010, 3'b001: is_ctrl = 1'b1;
      default:                is_ctrl = 1'b0;
    endcase
  end

  assign in_ready_o = (state_q == StIdle);
  // A flush in the accept cycle drops the instruction entirely.
  assign accept     = in_valid_i && in_ready_o && is_ctrl && !flush_i;

  // ---------------------------------------------------------------------------
  // Branch condition from the SUB rs1-rs2 flags.
  // ---------------------------------------------------------------------------
  always_comb begin
    cond       = 1'b0;
    f3_illegal = 1'b0;
    unique case (in_funct3_i)
      3'b000:  cond = zero_i;                      // BEQ
      3'b001:  cond = !zero_i;                     // BNE
      3'b100:  cond = sign_i ^ overflow_i;         // BLT
      3'b101:  cond = !(sign_i ^ overflow_i);      // BGE
      3'b110:  cond = carry_i;                     // BLTU, borrow = rs1 < rs2
      3'b111:  cond = !carry_i;                    // BGEU
      default: f3_illegal = 1'b1;                  // 010 / 011
    endcase
  end

  assign br_illegal = in_is_branch_i && f3_illegal;

  // ---------------------------------------------------------------------------
  // Outcome and next PC (all arithmetic wraps mod 2^32).
  // ---------------------------------------------------------------------------
  assign taken       = in_is_jal_i || in_is_jalr_i || (in_is_branch_i && cond);
  assign pc_plus_imm = in_pc_i + in_imm_i;
  assign pc_plus_4   = in_pc_i + 32'd4;
  assign jalr_sum    = in_rs1_i + in_imm_i;
  assign jalr_target = {jalr_sum[31:1], 1'b0};

  always_comb begin
    target = pc_plus_4;
    if (taken) begin
      target = in_is_jalr_i ? jalr_target : pc_plus_imm;
    end
  end

  assign misalign = taken && target[1];

  // JALR has no target prediction, so it always redirects. Faulting results
  // (illegal or misaligned) are reported via their flags and never redirect.
  assign redirect = !br_illegal && !misalign &&
                    (in_is_jalr_i || (taken != in_pred_taken_i));

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept && redirect) begin
          state_d = StRedir;
        end
      end
      StRedir: begin
        if (redir_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Flush wins over everything, including a same-cycle redirect handshake.
    if (flush_i) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered result, redirect PC and counters.
  // The redirect PC has its own register so it stays put for the whole
  // redirect regardless of what happens to the result registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_valid_q    <= 1'b0;
      res_taken_q    <= 1'b0;
      res_target_q   <= 32'd0;
      res_illegal_q  <= 1'b0;
      res_misalign_q <= 1'b0;
      redir_pc_q     <= 32'd0;
      branch_cnt_q   <= '0;
      mispred_cnt_q  <= '0;
    end else begin
      res_valid_q <= accept;
      if (accept) begin
        res_taken_q    <= taken;
        res_target_q   <= target;
        res_illegal_q  <= br_illegal;
        res_misalign_q <= misalign;
        branch_cnt_q   <= branch_cnt_q + CNT_W'(1);
        if (redirect) begin
          redir_pc_q    <= target;
          mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign res_valid_o    = res_valid_q;
  assign res_taken_o    = res_taken_q;
  assign res_target_o   = res_target_q;
  assign res_illegal_o  = res_illegal_q;
  assign res_misalign_o = res_misalign_q;
  assign redir_valid_o  = (state_q == StRedir);
  assign redir_pc_o     = redir_pc_q;
  assign branch_cnt_o   = branch_cnt_q;
  assign mispred_cnt_o  = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver (counters narrowed to 4 bits so
// wrap-around is reachable quickly).
module tb_branch_resolver;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic          in_is_branch, in_is_jal, in_is_jalr;
  logic [2:0]    in_funct3;
  logic [31:0]   in_pc, in_imm, in_rs1;
  logic          in_pred_taken;
  logic          zero, sign, overflow, carry;
  logic          res_valid, res_taken, res_illegal, res_misalign;
  logic [31:0]   res_target;
  logic          redir_valid, redir_ready;
  logic [31:0]   redir_pc;
  logic [CW-1:0] branch_cnt, mispred_cnt;

  always #5 clk = ~clk;

  branch_resolver #(.CNT_W(CW)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .flush_i         (flush),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .in_is_branch_i  (in_is_branch),
    .in_is_jal_i     (in_is_jal),
    .in_is_jalr_i    (in_is_jalr),
    .in_funct3_i     (in_funct3),
    .in_pc_i         (in_pc),
    .in_imm_i        (in_imm),
    .in_rs1_i        (in_rs1),
    .in_pred_taken_i (in_pred_taken),
    .zero_i          (zero),
    .sign_i          (sign),
    .overflow_i      (overflow),
    .carry_i         (carry),
    .res_valid_o     (res_valid),
    .res_taken_o     (res_taken),
    .res_target_o    (res_target),
    .res_illegal_o   (res_illegal),
    .res_misalign_o  (res_misalign),
    .redir_valid_o   (redir_valid),
    .redir_ready_i   (redir_ready),
    .redir_pc_o      (redir_pc),
    .branch_cnt_o    (branch_cnt),
    .mispred_cnt_o   (mispred_cnt)
  );

  // cls = {branch, jal, jalr}; fl = {zero, sign, overflow, carry}
  typedef struct {
    logic [2:0]  cls;
    logic [2:0]  f3;
    logic [31:0] pc, imm, rs1;
    logic        pred;
    logic [3:0]  fl;
    logic        tk;
    logic [31:0] tgt;
    logic        ill, mis, rd;
  } vec_t;

  typedef struct {
    logic          tk;
    logic [31:0]   tgt;
    logic          ill, mis;
    logic [CW-1:0] bc, mc;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  vec_t          vecs[15];
  vec_t          v;
  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] exp_bc = '0;
  logic [CW-1:0] exp_mc = '0;

  function automatic vec_t mk(logic [2:0] cls, logic [2:0] f3, logic [31:0] pc, imm, rs1,
                              logic pred, logic [3:0] fl, logic tk, logic [31:0] tgt,
                              logic ill, mis, rd);
    vec_t r;
    r.cls = cls; r.f3 = f3; r.pc = pc; r.imm = imm; r.rs1 = rs1; r.pred = pred; r.fl = fl;
    r.tk = tk; r.tgt = tgt; r.ill = ill; r.mis = mis; r.rd = rd;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every res_valid pulse must match the oldest pending entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && res_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_res: got res_valid=1 expected 0");
      end else begin
        mon_e = sb.pop_front();
        chk("res_taken", {31'd0, res_taken}, {31'd0, mon_e.tk});
        chk("res_target", res_target, mon_e.tgt);
        chk("res_illegal", {31'd0, res_illegal}, {31'd0, mon_e.ill});
        chk("res_misalign", {31'd0, res_misalign}, {31'd0, mon_e.mis});
        chk("branch_cnt", 32'(branch_cnt), 32'(mon_e.bc));
        chk("mispred_cnt", 32'(mispred_cnt), 32'(mon_e.mc));
      end
    end
  end

  // Presents one instruction for one cycle (waiting for in_ready first) and
  // returns at the negedge of the following cycle, where the result is visible.
  task automatic issue(input vec_t x, input logic fl, input logic push);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got in_ready=%b expected 1", in_ready);
    end
    {in_is_branch, in_is_jal, in_is_jalr} = x.cls;
    in_funct3 = x.f3; in_pc = x.pc; in_imm = x.imm; in_rs1 = x.rs1;
    in_pred_taken = x.pred;
    {zero, sign, overflow, carry} = x.fl;
    flush = fl;
    in_valid = 1'b1;
    if (push) begin
      exp_bc = exp_bc + 1'b1;
      if (x.rd) exp_mc = exp_mc + 1'b1;
      e.tk = x.tk; e.tgt = x.tgt; e.ill = x.ill; e.mis = x.mis; e.bc = exp_bc; e.mc = exp_mc;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b0;
    {in_is_branch, in_is_jal, in_is_jalr} = 3'b000;
  endtask

  task automatic handle_redir(input vec_t x, input int idx);
    chk($sformatf("v%0d_redir_valid", idx), {31'd0, redir_valid}, {31'd0, x.rd});
    if (x.rd) begin
      chk($sformatf("v%0d_redir_pc", idx), redir_pc, x.tgt);
      chk($sformatf("v%0d_ready_in_redir", idx), {31'd0, in_ready}, 32'd0);
      redir_ready = 1'b1;
      @(negedge clk);
      redir_ready = 1'b0;
      chk($sformatf("v%0d_redir_done", idx), {31'd0, redir_valid}, 32'd0);
      chk($sformatf("v%0d_ready_back", idx), {31'd0, in_ready}, 32'd1);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_flags"}, {27'd0, res_valid, res_taken, res_illegal, res_misalign, redir_valid},
        32'd0);
    chk({tag, "_res_target"}, res_target, 32'd0);
    chk({tag, "_redir_pc"}, redir_pc, 32'd0);
    chk({tag, "_cnts"}, {24'd0, branch_cnt, mispred_cnt}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; redir_ready = 1'b0;
    {in_is_branch, in_is_jal, in_is_jalr} = 3'b000;
    in_funct3 = '0; in_pc = '0; in_imm = '0; in_rs1 = '0; in_pred_taken = 1'b0;
    {zero, sign, overflow, carry} = 4'b0000;

    //          cls     f3      pc            imm           rs1           pr fl       tk tgt  il ms rd
    vecs[0]  = mk(3'b100, 3'b000, 32'h100, 32'h20, 32'hDEAD0000, 0, 4'b1000, 1, 32'h120, 0, 0, 1);
    vecs[1]  = mk(3'b100, 3'b100, 32'h200, 32'h40, 32'hDEAD0000, 0, 4'b0110, 0, 32'h204, 0, 0, 0);
    vecs[2]  = mk(3'b001, 3'b000, 32'h50, 32'h4, 32'h1003, 0, 4'b0000, 1, 32'h1006, 0, 1, 0);
    vecs[3]  = mk(3'b001, 3'b000, 32'h50, 32'h3, 32'h1001, 0, 4'b0000, 1, 32'h1004, 0, 0, 1);
    vecs[4]  = mk(3'b100, 3'b010, 32'h300, 32'h10, 32'hDEAD0000, 1, 4'b1000, 0, 32'h304, 1, 0, 0);
    vecs[5]  = mk(3'b100, 3'b001, 32'h400, 32'hFFFFFFF0, 32'hDEAD0000, 1, 4'b0000, 1, 32'h3F0,
                  0, 0, 0);
    vecs[6]  = mk(3'b100, 3'b101, 32'h500, 32'h8, 32'hDEAD0000, 1, 4'b0100, 0, 32'h504, 0, 0, 1);
    vecs[7]  = mk(3'b100, 3'b110, 32'h600, 32'h100, 32'hDEAD0000, 0, 4'b0001, 1, 32'h700, 0, 0, 1);
    vecs[8]  = mk(3'b100, 3'b111, 32'h700, 32'h20, 32'hDEAD0000, 0, 4'b0001, 0, 32'h704, 0, 0, 0);
    vecs[9]  = mk(3'b010, 3'b000, 32'h800, 32'h1000, 32'hDEAD0000, 1, 4'b0000, 1, 32'h1800,
                  0, 0, 0);
    vecs[10] = mk(3'b010, 3'b000, 32'h900, 32'h2, 32'hDEAD0000, 1, 4'b0000, 1, 32'h902, 0, 1, 0);
    vecs[11] = mk(3'b100, 3'b011, 32'hA00, 32'h40, 32'hDEAD0000, 0, 4'b0001, 0, 32'hA04, 1, 0, 0);
    vecs[12] = mk(3'b100, 3'b111, 32'hFFFFFFF0, 32'h20, 32'hDEAD0000, 1, 4'b0000, 1, 32'h10,
                  0, 0, 0);
    vecs[13] = mk(3'b100, 3'b100, 32'hB00, 32'hFFFFFF00, 32'hDEAD0000, 1, 4'b0100, 1, 32'hA00,
                  0, 0, 0);
    vecs[14] = mk(3'b010, 3'b000, 32'hC00, 32'h8, 32'hDEAD0000, 0, 4'b0000, 1, 32'hC08, 0, 0, 1);

    #7;
    chk_all_zero("reset");
    #5 rst_n = 1'b1;

    // Table-driven resolution checks
    for (int i = 0; i < 15; i++) begin
      issue(vecs[i], 1'b0, 1'b1);
      handle_redir(vecs[i], i);
    end

    // Redirect held for 5 cycles with fetch not ready; in_valid during REDIR ignored
    v = mk(3'b100, 3'b000, 32'h1000, 32'h40, 32'h0, 0, 4'b1000, 1, 32'h1040, 0, 0, 1);
    issue(v, 1'b0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall%0d_valid", c), {31'd0, redir_valid}, 32'd1);
      chk($sformatf("stall%0d_pc", c), redir_pc, 32'h1040);
      chk($sformatf("stall%0d_ready", c), {31'd0, in_ready}, 32'd0);
      in_valid = (c == 1);
      in_is_branch = (c == 1);
      @(negedge clk);
    end
    in_valid = 1'b0; in_is_branch = 1'b0;
    redir_ready = 1'b1;
    @(negedge clk);
    redir_ready = 1'b0;
    chk("stall_release_valid", {31'd0, redir_valid}, 32'd0);
    chk("stall_release_ready", {31'd0, in_ready}, 32'd1);
    chk("stall_bc", 32'(branch_cnt), 32'(exp_bc));

    // Flush during REDIR
    v.pc = 32'h2000; v.tgt = 32'h2040;
    issue(v, 1'b0, 1'b1);
    chk("flushredir_pre", {31'd0, redir_valid}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flushredir_valid", {31'd0, redir_valid}, 32'd0);
    chk("flushredir_ready", {31'd0, in_ready}, 32'd1);
    chk("flushredir_mc", 32'(mispred_cnt), 32'(exp_mc));

    // Flush coincident with accept: instruction dropped
    issue(v, 1'b1, 1'b0);
    chk("flushacc_redir", {31'd0, redir_valid}, 32'd0);
    chk("flushacc_bc", 32'(branch_cnt), 32'(exp_bc));
    chk("flushacc_mc", 32'(mispred_cnt), 32'(exp_mc));

    // Flush coincident with redirect handshake: no double count
    issue(v, 1'b0, 1'b1);
    flush = 1'b1; redir_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; redir_ready = 1'b0;
    chk("flushhs_valid", {31'd0, redir_valid}, 32'd0);
    @(negedge clk);
    chk("flushhs_mc", 32'(mispred_cnt), 32'(exp_mc));

    // Non-control instruction: ignored
    v.cls = 3'b000;
    issue(v, 1'b0, 1'b0);
    chk("nonctrl_redir", {31'd0, redir_valid}, 32'd0);
    chk("nonctrl_bc", 32'(branch_cnt), 32'(exp_bc));
    v.cls = 3'b110;  // two class bits: also ignored
    issue(v, 1'b0, 1'b0);
    chk("twocls_bc", 32'(branch_cnt), 32'(exp_bc));

    // Counter wrap: reset, then 17 correctly predicted branches
    @(negedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    exp_bc = '0; exp_mc = '0;
    #3 rst_n = 1'b1;
    v = mk(3'b100, 3'b000, 32'h3000, 32'h80, 32'h0, 0, 4'b0000, 0, 32'h3004, 0, 0, 0);
    for (int k = 0; k < 17; k++) begin
      issue(v, 1'b0, 1'b1);
    end
    chk("wrap_bc", 32'(branch_cnt), 32'd1);
    chk("wrap_mc", 32'(mispred_cnt), 32'd0);

    // Async reset in the middle of REDIR
    v = mk(3'b100, 3'b001, 32'h4000, 32'h100, 32'h0, 0, 4'b0000, 1, 32'h4100, 0, 0, 1);
    issue(v, 1'b0, 1'b1);
    chk("midreset_pre", {31'd0, redir_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    sb.delete();
    exp_bc = '0; exp_mc = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
